// File: rtl/regfile_write_port_pkg.sv
// Shared constants and types for the register-file write port.
// The pending-write slot is a two-state machine: EMPTY or FULL.
`timescale 1ns/1ps
package regfile_write_port_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int NUM_REGS  = 16;
  localparam int PC_IDX    = 15;
  localparam int PC_STEP   = 4;
  localparam int ADDR_W    = $clog2(NUM_REGS);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/regfile_write_port_decoder.sv
// One-hot load-enable decoder, the write-side counterpart of the 16-to-1 read mux.
// Drives no enable at all when i_en is low.
`timescale 1ns/1ps
module decoder_4x16
  import regfile_write_port_pkg::*;
(
  input  logic [ADDR_W-1:0]   i_idx,
  input  logic                i_en,
  output logic [NUM_REGS-1:0] o_load
);

  always_comb begin
    o_load = '0;
    if (i_en) o_load[i_idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_port.sv
// Sixteen-entry register file with a single buffered write port and a PC (R15) auto-increment.
// Writes land in a one-deep pending slot and commit one edge later unless hold freezes the commit stage.
`timescale 1ns/1ps
module regfile_write_port
  import regfile_write_port_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              hold,
  input  logic              pc_en,
  output logic              wr_done,
  output logic [WIDTH-1:0]  Q0,
  output logic [WIDTH-1:0]  Q1,
  output logic [WIDTH-1:0]  Q2,
  output logic [WIDTH-1:0]  Q3,
  output logic [WIDTH-1:0]  Q4,
  output logic [WIDTH-1:0]  Q5,
  output logic [WIDTH-1:0]  Q6,
  output logic [WIDTH-1:0]  Q7,
  output logic [WIDTH-1:0]  Q8,
  output logic [WIDTH-1:0]  Q9,
  output logic [WIDTH-1:0]  Q10,
  output logic [WIDTH-1:0]  Q11,
  output logic [WIDTH-1:0]  Q12,
  output logic [WIDTH-1:0]  Q13,
  output logic [WIDTH-1:0]  Q14,
  output logic [WIDTH-1:0]  Q15
);

  slot_state_e           r_state;
  slot_state_e           w_nextState;
  logic [ADDR_W-1:0]     r_pendAddr;
  logic [WIDTH-1:0]      r_pendData;
  logic                  r_wrDone;
  logic                  w_pendValid;
  logic                  w_accept;
  logic                  w_commit;
  logic [NUM_REGS-1:0]   w_load;
  logic [WIDTH-1:0]      r_regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_nextState;
  end

  // A same-edge accept refills the slot even while the old entry commits.
  always_comb begin
    w_nextState = r_state;
    if (w_accept)      w_nextState = FULL;
    else if (w_commit) w_nextState = EMPTY;
  end

  always_comb begin
    w_pendValid = (r_state == FULL);
    wr_ready    = !w_pendValid || !hold;
    w_accept    = wr_valid && wr_ready;
    w_commit    = w_pendValid && !hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pendAddr <= '0;
      r_pendData <= '0;
      r_wrDone   <= 1'b0;
    end else begin
      r_wrDone <= w_commit;
      if (w_accept) begin
        r_pendAddr <= wr_addr;
        r_pendData <= wr_data;
      end
    end
  end

  decoder_4x16 u_decoder (
    .i_idx  (r_pendAddr),
    .i_en   (w_commit),
    .o_load (w_load)
  );

  // A commit into the PC slot wins over the auto-increment on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_load[i])
          r_regs[i] <= r_pendData;
        else if (i == PC_IDX && pc_en)
          r_regs[i] <= r_regs[i] + WIDTH'(PC_STEP);
      end
    end
  end

  assign wr_done = r_wrDone;
  assign Q0  = r_regs[0];
  assign Q1  = r_regs[1];
  assign Q2  = r_regs[2];
  assign Q3  = r_regs[3];
  assign Q4  = r_regs[4];
  assign Q5  = r_regs[5];
  assign Q6  = r_regs[6];
  assign Q7  = r_regs[7];
  assign Q8  = r_regs[8];
  assign Q9  = r_regs[9];
  assign Q10 = r_regs[10];
  assign Q11 = r_regs[11];
  assign Q12 = r_regs[12];
  assign Q13 = r_regs[13];
  assign Q14 = r_regs[14];
  assign Q15 = r_regs[15];

endmodule

// File: tb/tb_regfile_write_port.sv
// Self-checking bench for regfile_write_port: a vector table, directed corner sequences and a
// random phase, all compared against a reference model with a commit scoreboard.
`timescale 1ns/1ps
module tb_regfile_write_port;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        hold;
    logic        pcen;
    logic        expReady;
    logic        expDone;
    int          chkIdx;
    logic [31:0] chkVal;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrValid;
  logic        wrReady;
  logic [3:0]  wrAddr;
  logic [31:0] wrData;
  logic        hold;
  logic        pcEn;
  logic        wrDone;
  logic [31:0] q0, q1, q2, q3, q4, q5, q6, q7, q8, q9, q10, q11, q12, q13, q14, q15;
  logic [31:0] qs [16];

  int          checkCount = 0;
  int          passCount  = 0;

  logic [31:0] mReg [16];
  logic [31:0] prevQ [16];
  logic        mPendValid;
  logic [3:0]  mPendAddr;
  logic [31:0] mPendData;
  logic        mDone;
  logic        sampledReady;
  int          lastChanges;
  sb_t         sbq [$];
  vec_t        vecs [$];

  always #5 clk = ~clk;

  regfile_write_port #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wrValid),
    .wr_ready (wrReady),
    .wr_addr  (wrAddr),
    .wr_data  (wrData),
    .hold     (hold),
    .pc_en    (pcEn),
    .wr_done  (wrDone),
    .Q0 (q0),  .Q1 (q1),  .Q2 (q2),  .Q3 (q3),
    .Q4 (q4),  .Q5 (q5),  .Q6 (q6),  .Q7 (q7),
    .Q8 (q8),  .Q9 (q9),  .Q10(q10), .Q11(q11),
    .Q12(q12), .Q13(q13), .Q14(q14), .Q15(q15)
  );

  always_comb begin
    qs[0]  = q0;  qs[1]  = q1;  qs[2]  = q2;  qs[3]  = q3;
    qs[4]  = q4;  qs[5]  = q5;  qs[6]  = q6;  qs[7]  = q7;
    qs[8]  = q8;  qs[9]  = q9;  qs[10] = q10; qs[11] = q11;
    qs[12] = q12; qs[13] = q13; qs[14] = q14; qs[15] = q15;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    else
      passCount++;
  endtask

  // Compares every register against the model and counts how many changed this edge.
  task automatic checkRegs();
    int bad;
    int firstBad;
    bad = 0;
    firstBad = -1;
    lastChanges = 0;
    for (int i = 0; i < 16; i++) begin
      if (qs[i] !== mReg[i]) begin
        bad++;
        if (firstBad < 0) firstBad = i;
      end
      if (qs[i] !== prevQ[i]) lastChanges++;
    end
    if (firstBad >= 0)
      $display("[TB] Q%0d actual=%h model=%h", firstBad, qs[firstBad], mReg[firstBad]);
    checkOutput("regs_mismatch_count", 32'(bad), 32'd0);
  endtask

  // Drives one cycle of inputs, advances the model and checks the outcome after the edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] a,
                               input logic [31:0] d, input logic h, input logic p);
    logic mReady;
    logic commit;
    logic acc;
    sb_t  e;
    rst = r; wrValid = v; wrAddr = a; wrData = d; hold = h; pcEn = p;
    #1;
    mReady = !mPendValid || !h;
    sampledReady = wrReady;
    checkOutput("wr_ready", 32'(wrReady), 32'(mReady));
    for (int i = 0; i < 16; i++) prevQ[i] = qs[i];
    if (r) begin
      for (int i = 0; i < 16; i++) mReg[i] = '0;
      mPendValid = 1'b0;
      mDone = 1'b0;
      sbq.delete();
    end else begin
      commit = mPendValid && !h;
      acc    = v && mReady;
      if (commit) mReg[mPendAddr] = mPendData;
      if (p && !(commit && mPendAddr == 4'd15)) mReg[15] = mReg[15] + 32'd4;
      if (acc) begin
        e.addr = a;
        e.data = d;
        sbq.push_back(e);
        mPendAddr = a;
        mPendData = d;
      end
      mPendValid = acc ? 1'b1 : (commit ? 1'b0 : mPendValid);
      mDone = commit;
    end
    @(posedge clk);
    #1;
    checkOutput("wr_done", 32'(wrDone), 32'(mDone));
    if (wrDone === 1'b1) begin
      if (sbq.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        checkOutput($sformatf("sb_commit_Q%0d", e.addr), qs[e.addr], e.data);
      end
    end
    checkRegs();
  endtask

  task automatic addVec(input logic r, input logic v, input logic [3:0] a, input logic [31:0] d,
                        input logic h, input logic p, input logic er, input logic ed,
                        input int ci, input logic [31:0] cv);
    vec_t t;
    t.rst = r; t.valid = v; t.addr = a; t.data = d; t.hold = h; t.pcen = p;
    t.expReady = er; t.expDone = ed; t.chkIdx = ci; t.chkVal = cv;
    vecs.push_back(t);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] dat;
    rst = 1'b1; wrValid = 1'b0; wrAddr = '0; wrData = '0; hold = 1'b0; pcEn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      mReg[i] = '0;
      prevQ[i] = '0;
    end
    mPendValid = 1'b0; mPendAddr = '0; mPendData = '0; mDone = 1'b0;

    checkOutput("reset_wr_ready", 32'(wrReady), 32'd1);
    checkOutput("reset_wr_done", 32'(wrDone), 32'd0);
    checkRegs();
    rst = 1'b0;

    // rst valid addr data hold pc | ready done chkIdx chkVal
    addVec(0, 1, 4'd3,  32'hDEADBEEF, 0, 0, 1, 0, 3,  32'h0);
    addVec(0, 0, 4'd0,  32'h0,        0, 0, 1, 1, 3,  32'hDEADBEEF);
    addVec(0, 0, 4'd0,  32'h0,        0, 0, 1, 0, 3,  32'hDEADBEEF);
    addVec(0, 1, 4'd1,  32'h11111111, 0, 0, 1, 0, 1,  32'h0);
    addVec(0, 1, 4'd2,  32'h22222222, 0, 0, 1, 1, 1,  32'h11111111);
    addVec(0, 0, 4'd0,  32'h0,        0, 0, 1, 1, 2,  32'h22222222);
    addVec(0, 0, 4'd0,  32'h0,        0, 0, 1, 0, 2,  32'h22222222);
    addVec(0, 1, 4'd5,  32'hA5A5A5A5, 0, 0, 1, 0, 5,  32'h0);
    addVec(0, 0, 4'd0,  32'h0,        1, 0, 0, 0, 5,  32'h0);
    addVec(0, 0, 4'd0,  32'h0,        1, 0, 0, 0, 5,  32'h0);
    addVec(0, 1, 4'd6,  32'h66666666, 1, 0, 0, 0, 5,  32'h0);
    addVec(0, 0, 4'd0,  32'h0,        0, 0, 1, 1, 5,  32'hA5A5A5A5);
    addVec(0, 0, 4'd0,  32'h0,        0, 0, 1, 0, 6,  32'h0);
    addVec(0, 1, 4'd15, 32'hFFFFFFFC, 0, 0, 1, 0, 15, 32'h0);
    addVec(0, 0, 4'd0,  32'h0,        0, 1, 1, 1, 15, 32'hFFFFFFFC);
    addVec(0, 0, 4'd0,  32'h0,        0, 1, 1, 0, 15, 32'h00000000);
    addVec(0, 1, 4'd15, 32'h00001000, 0, 1, 1, 0, 15, 32'h00000004);
    addVec(0, 0, 4'd0,  32'h0,        0, 1, 1, 1, 15, 32'h00001000);
    addVec(0, 0, 4'd0,  32'h0,        1, 1, 1, 0, 15, 32'h00001004);

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].rst, vecs[k].valid, vecs[k].addr, vecs[k].data,
                    vecs[k].hold, vecs[k].pcen);
      checkOutput($sformatf("vec%0d_ready", k), 32'(sampledReady), 32'(vecs[k].expReady));
      checkOutput($sformatf("vec%0d_done", k), 32'(wrDone), 32'(vecs[k].expDone));
      if (vecs[k].chkIdx >= 0)
        checkOutput($sformatf("vec%0d_Q%0d", k, vecs[k].chkIdx), qs[vecs[k].chkIdx], vecs[k].chkVal);
    end

    // Reset the edge after an accept: the pending write must vanish, wr_valid is ignored.
    applyStimulus(0, 1, 4'd7, 32'h12345678, 0, 0);
    applyStimulus(1, 1, 4'd8, 32'h88888888, 0, 1);
    checkOutput("rst_pending_Q7", q7, 32'h0);
    checkOutput("rst_pending_Q8", q8, 32'h0);
    checkOutput("rst_pending_done", 32'(wrDone), 32'd0);
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0);
    checkOutput("post_rst_ready", 32'(sampledReady), 32'd1);
    checkOutput("post_rst_done", 32'(wrDone), 32'd0);
    checkOutput("post_rst_Q7", q7, 32'h0);

    // Every index written once, back to back; exactly one register changes per commit.
    for (int i = 0; i <= 16; i++) begin
      dat = 32'hA0000001 + 32'(i) * 32'h01010101;
      if (i < 16) applyStimulus(0, 1, 4'(i), dat, 0, 0);
      else        applyStimulus(0, 0, 4'd0, 32'h0, 0, 0);
      if (i > 0) checkOutput($sformatf("one_change_commit%0d", i - 1), 32'(lastChanges), 32'd1);
    end
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("all_idx_Q%0d", i), qs[i], 32'hA0000001 + 32'(i) * 32'h01010101);

    // Random traffic against the model.
    for (int n = 0; n < 200; n++) begin
      applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom), 4'($urandom), $urandom,
                    ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
